// File: rtl/rgb_pwm_fader.sv
// rgb_pwm_fader
//
// Generates the three PWM enables for the iCE40 SB_RGBA_DRV LED driver
// (RGB0PWM/RGB1PWM/RGB2PWM) from per-channel duty values. A new colour is
// taken over a valid/ready handshake and applied either at once (jump) or as
// a linear fade that moves each channel one LSB toward the target every
// STEP_DIV PWM frames. Duty changes only land on frame boundaries.
//
// Ports:
//   clk          in   system clock (12 MHz)
//   rst          in   synchronous reset, active-high
//   color_data   in   {blue, green, red} target duties, WIDTH bits each
//   color_valid  in   color_data/fade_en valid
//   color_ready  out  colour can be accepted this cycle (IDLE, not in reset)
//   fade_en      in   1 = fade to the colour, 0 = jump to it
//   busy         out  fade in progress
//   pwm_red      out  to SB_RGBA_DRV RGB1PWM
//   pwm_green    out  to SB_RGBA_DRV RGB0PWM
//   pwm_blue     out  to SB_RGBA_DRV RGB2PWM
module rgb_pwm_fader #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 47,
  parameter int STEP_DIV = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3*WIDTH-1:0] color_data,
  input  logic               color_valid,
  output logic               color_ready,
  input  logic               fade_en,
  output logic               busy,
  output logic               pwm_red,
  output logic               pwm_green,
  output logic               pwm_blue
);

  localparam int PW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
  localparam int FW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [PW-1:0]    PRESC_MAX = PW'(PRESCALE);
  localparam logic [PW-1:0]    PRESC_ONE = PW'(1);
  localparam logic [WIDTH-1:0] CNT_MAX   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);
  localparam logic [FW-1:0]    FRAME_MAX = FW'(STEP_DIV - 1);
  localparam logic [FW-1:0]    FRAME_ONE = FW'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FADE = 1'b1
  } state_t;

  // Channel index 0 = red, 1 = green, 2 = blue, matching color_data packing.
  state_t                  state_q,  state_d;
  logic [PW-1:0]           presc_q,  presc_d;
  logic [WIDTH-1:0]        cnt_q,    cnt_d;
  logic [FW-1:0]           frame_q,  frame_d;
  logic [2:0][WIDTH-1:0]   cur_q,    cur_d;
  logic [2:0][WIDTH-1:0]   target_q, target_d;
  logic [2:0][WIDTH-1:0]   active_q, active_d;
  logic [2:0]              pwm_q,    pwm_d;
  logic [2:0][WIDTH-1:0]   stepped_s;
  logic                    tick_s;
  logic                    frame_end_s;

  // One LSB toward the target; never passes it, so no wrap is possible.
  function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] tgt);
    logic [WIDTH-1:0] nxt;
    if (cur < tgt) begin
      nxt = cur + CNT_ONE;
    end else if (cur > tgt) begin
      nxt = cur - CNT_ONE;
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

  assign tick_s      = (presc_q == PRESC_MAX);
  assign frame_end_s = tick_s && (cnt_q == CNT_MAX);

  // Reset gates the outputs so the handshake and LED are quiet for every reset cycle.
  assign color_ready = (state_q == IDLE) && !rst;
  assign busy        = (state_q == FADE) && !rst;
  assign pwm_red     = pwm_q[0] && !rst;
  assign pwm_green   = pwm_q[1] && !rst;
  assign pwm_blue    = pwm_q[2] && !rst;

  // Prescaler, PWM counter, frame-aligned duty load and compare.
  always_comb begin
    presc_d  = presc_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    pwm_d    = 3'b000;
    if (tick_s) begin
      presc_d = {PW{1'b0}};
      cnt_d   = cnt_q + CNT_ONE;
    end else begin
      presc_d = presc_q + PRESC_ONE;
      cnt_d   = cnt_q;
    end
    // Loading on frame_end keeps each frame's duty constant (glitch-free).
    if (frame_end_s) begin
      active_d = cur_q;
    end else begin
      active_d = active_q;
    end
    for (int i = 0; i < 3; i++) begin
      pwm_d[i] = (cnt_q < active_q[i]);
    end
  end

  // Candidate next duty for each channel if this frame_end is a fade step.
  always_comb begin
    stepped_s = cur_q;
    for (int i = 0; i < 3; i++) begin
      stepped_s[i] = step_toward(cur_q[i], target_q[i]);
    end
  end

  // Fade FSM: handshake in IDLE, STEP_DIV-frame stepping in FADE.
  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    cur_d    = cur_q;
    target_d = target_q;
    case (state_q)
      IDLE: begin
        frame_d = {FW{1'b0}};
        if (color_valid) begin
          target_d = color_data;
          if (fade_en) begin
            state_d = FADE;
          end else begin
            cur_d   = color_data;
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      FADE: begin
        if (frame_end_s) begin
          if (frame_q == FRAME_MAX) begin
            frame_d = {FW{1'b0}};
            cur_d   = stepped_s;
            // Equal-target fades also leave here, at their first step check.
            if (stepped_s == target_q) begin
              state_d = IDLE;
            end else begin
              state_d = FADE;
            end
          end else begin
            frame_d = frame_q + FRAME_ONE;
          end
        end else begin
          frame_d = frame_q;
        end
      end
      default: begin
        state_d = IDLE;
        frame_d = {FW{1'b0}};
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      presc_q  <= {PW{1'b0}};
      cnt_q    <= {WIDTH{1'b0}};
      frame_q  <= {FW{1'b0}};
      cur_q    <= {(3*WIDTH){1'b0}};
      target_q <= {(3*WIDTH){1'b0}};
      active_q <= {(3*WIDTH){1'b0}};
      pwm_q    <= 3'b000;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      frame_q  <= frame_d;
      cur_q    <= cur_d;
      target_q <= target_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end

endmodule
